serial_tx_scheduler: RTL and testbench

//  Round-robin scheduler that shares one 12-bit serializer among NREQ requesters.

---
 rtl/serial_tx_scheduler.sv | 120 ++++++++++++
 tb/tb_serial_tx_scheduler.sv | 271 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/serial_tx_scheduler.sv
// Round-robin scheduler sharing one serializer among NREQ requesters:
// grants one requester, latches its word, drives load/send for one frame, then acks.
module serial_tx_scheduler #(
  parameter int WIDTH = 12,
  parameter int NREQ  = 4,
  parameter int GAP   = 1
) (
  input  logic                      CLK,
  input  logic                      rst,
  input  logic [NREQ-1:0]           req,
  input  logic [NREQ*WIDTH-1:0]     req_data,
  output logic [NREQ-1:0]           ack,
  output logic [$clog2(NREQ)-1:0]   grant_id,
  output logic                      busy,
  output logic                      ser_load,
  output logic                      ser_send,
  output logic [WIDTH-1:0]          ser_data
);

  localparam int IW = $clog2(NREQ);
  localparam int CW = $clog2(WIDTH + 1);
  localparam int GW = $clog2(GAP + 1) + 1;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_LOAD = 2'd1;
  localparam logic [1:0] ST_SEND = 2'd2;
  localparam logic [1:0] ST_GAP  = 2'd3;

  logic [1:0]    state_r;
  logic [CW-1:0] cnt_r;
  logic [GW-1:0] gcnt_r;
  logic [IW-1:0] rr_ptr_r;
  logic [IW-1:0] gnt_s;
  logic [IW-1:0] idx_s;

  // Round-robin pick: scan downward so the nearest set bit after rr_ptr_r wins.
  always_comb begin
    gnt_s = '0;
    idx_s = '0;
    for (int k = NREQ; k >= 1; k--) begin
      idx_s = IW'((int'(rr_ptr_r) + k) % NREQ);
      if (req[idx_s]) begin
        gnt_s = idx_s;
      end else begin
        gnt_s = gnt_s;
      end
    end
  end

  // Frame sequencer; every output is a register updated alongside the state.
  always_ff @(posedge CLK or posedge rst) begin
    if (rst) begin
      state_r  <= ST_IDLE;
      cnt_r    <= '0;
      gcnt_r   <= '0;
      rr_ptr_r <= IW'(NREQ - 1);
      ack      <= '0;
      grant_id <= '0;
      busy     <= 1'b0;
      ser_load <= 1'b0;
      ser_send <= 1'b0;
      ser_data <= '0;
    end else begin
      case (state_r)
        ST_IDLE: begin
          ack <= '0;
          if (req != '0) begin
            ser_data <= req_data[gnt_s*WIDTH +: WIDTH];
            grant_id <= gnt_s;
            rr_ptr_r <= gnt_s;
            ser_load <= 1'b1;
            busy     <= 1'b1;
            state_r  <= ST_LOAD;
          end else begin
            ser_load <= 1'b0;
            busy     <= 1'b0;
          end
        end
        ST_LOAD: begin
          ser_load <= 1'b0;
          ser_send <= 1'b1;
          cnt_r    <= '0;
          state_r  <= ST_SEND;
        end
        ST_SEND: begin
          if (cnt_r == CW'(WIDTH - 1)) begin
            ser_send <= 1'b0;
            ack      <= NREQ'(1) << grant_id;
            if (GAP == 0) begin
              busy    <= 1'b0;
              state_r <= ST_IDLE;
            end else begin
              gcnt_r  <= '0;
              state_r <= ST_GAP;
            end
          end else begin
            cnt_r <= cnt_r + CW'(1);
          end
        end
        ST_GAP: begin
          ack <= '0;
          if (gcnt_r == GW'(GAP - 1)) begin
            busy    <= 1'b0;
            state_r <= ST_IDLE;
          end else begin
            gcnt_r <= gcnt_r + GW'(1);
          end
        end
        default: begin
          state_r  <= ST_IDLE;
          ack      <= '0;
          busy     <= 1'b0;
          ser_load <= 1'b0;
          ser_send <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_serial_tx_scheduler.sv
// Scoreboard bench for serial_tx_scheduler: expected frames are queued when requests
// are driven and checked against each observed load/send/ack sequence.
module tb_serial_tx_scheduler;

  localparam int WIDTH = 12;
  localparam int NREQ  = 4;

  typedef struct {
    logic [1:0]  id;
    logic [11:0] data;
  } exp_t;

  logic              CLK = 1'b0;
  logic              rst;
  logic [3:0]        req;
  logic [47:0]       req_data;
  logic [3:0]        ack;
  logic [1:0]        grant_id;
  logic              busy, ser_load, ser_send;
  logic [11:0]       ser_data;

  logic [3:0]        req_b;
  logic [47:0]       data_b;
  logic [3:0]        ack_b;
  logic [1:0]        grant_id_b;
  logic              busy_b, ser_load_b, ser_send_b;
  logic [11:0]       ser_data_b;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;

  exp_t exp_q[$];
  exp_t cur;
  bit   in_frame = 1'b0;
  int   send_cnt = 0;
  int   frames_done = 0;
  bit   per_chk = 1'b0;
  bit   prev_valid = 1'b0;
  int   prev_load = 0;

  int   loads_b = 0;
  int   acks_b = 0;
  logic [1:0] cur_b = 2'd0;
  bit   prev_b_valid = 1'b0;
  int   prev_b = 0;
  bit   ack_b_valid = 1'b0;
  int   ack_b_cyc = 0;

  serial_tx_scheduler #(.WIDTH(WIDTH), .NREQ(NREQ), .GAP(1)) dut (
    .CLK(CLK), .rst(rst), .req(req), .req_data(req_data), .ack(ack),
    .grant_id(grant_id), .busy(busy), .ser_load(ser_load), .ser_send(ser_send),
    .ser_data(ser_data)
  );

  serial_tx_scheduler #(.WIDTH(WIDTH), .NREQ(NREQ), .GAP(0)) dut_b (
    .CLK(CLK), .rst(rst), .req(req_b), .req_data(data_b), .ack(ack_b),
    .grant_id(grant_id_b), .busy(busy_b), .ser_load(ser_load_b), .ser_send(ser_send_b),
    .ser_data(ser_data_b)
  );

  always #5 CLK = ~CLK;

  always @(posedge CLK) cyc <= cyc + 1;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h exp=%0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  task automatic push_exp(input logic [1:0] id, input logic [11:0] data);
    exp_t e;
    e.id   = id;
    e.data = data;
    exp_q.push_back(e);
  endtask

  task automatic wait_frames(input int target);
    int n = 0;
    while (frames_done < target && n < 400) begin
      @(negedge CLK);
      #1;
      n++;
    end
    if (frames_done < target) check_eq("timeout", 32'(frames_done), 32'(target));
  endtask

  task automatic do_reset();
    @(posedge CLK);
    #1 rst = 1'b1;
    @(posedge CLK);
    #1 rst = 1'b0;
    prev_valid = 1'b0;
  endtask

  // Main-DUT monitor: pops the scoreboard at each load and checks the whole frame.
  always @(negedge CLK) begin
    if (rst) begin
      in_frame = 1'b0;
    end else begin
      if (ser_load) begin
        check_eq("overlap", 32'(ser_send), 32'd0);
        if (exp_q.size() == 0) begin
          check_eq("q_empty", 32'(exp_q.size()), 32'd1);
        end else begin
          cur = exp_q.pop_front();
          check_eq("grant_id", 32'(grant_id), 32'(cur.id));
          check_eq("load_data", 32'(ser_data), 32'(cur.data));
          check_eq("busy_load", 32'(busy), 32'd1);
          if (prev_valid && per_chk) check_eq("period", 32'(cyc - prev_load), 32'd15);
          prev_load  = cyc;
          prev_valid = 1'b1;
          in_frame   = 1'b1;
          send_cnt   = 0;
        end
      end
      if (ser_send) begin
        send_cnt++;
        check_eq("send_data", 32'(ser_data), 32'(cur.data));
      end
      if (ack != 4'd0) begin
        check_eq("ack", 32'(ack), in_frame ? (32'd1 << cur.id) : 32'd0);
        check_eq("send_len", 32'(send_cnt), 32'(WIDTH));
        in_frame = 1'b0;
        frames_done++;
      end
    end
  end

  // GAP=0 monitor: alternating grants, 14-cycle period, load right after ack.
  always @(negedge CLK) begin
    if (!rst) begin
      if (ser_load_b) begin
        cur_b = 2'(loads_b % 2);
        check_eq("b_grant", 32'(grant_id_b), 32'(cur_b));
        check_eq("b_data", 32'(ser_data_b), 32'(data_b[cur_b*12 +: 12]));
        if (prev_b_valid) check_eq("b_period", 32'(cyc - prev_b), 32'd14);
        if (ack_b_valid) check_eq("b_load_after_ack", 32'(cyc - ack_b_cyc), 32'd1);
        prev_b       = cyc;
        prev_b_valid = 1'b1;
        loads_b++;
      end
      if (ack_b != 4'd0) begin
        check_eq("b_ack", 32'(ack_b), 32'd1 << cur_b);
        check_eq("b_busy_at_ack", 32'(busy_b), 32'd0);
        ack_b_cyc   = cyc;
        ack_b_valid = 1'b1;
        acks_b++;
      end
    end
  end

  initial begin
    int base;
    int n;
    rst      = 1'b1;
    req      = 4'd0;
    req_data = 48'd0;
    req_b    = 4'd0;
    data_b   = {12'h0B3, 12'h0B2, 12'h0B1, 12'h0B0};
    repeat (2) @(negedge CLK);
    check_eq("reset_state", 32'({ser_load, ser_send, ack, busy, ser_data, grant_id}), 32'd0);
    check_eq("reset_state_b", 32'({ser_load_b, ser_send_b, ack_b, busy_b, ser_data_b, grant_id_b}), 32'd0);
    @(posedge CLK);
    #1 rst = 1'b0;

    // single requester frame
    req_data[11:0] = 12'hA5C;
    req = 4'b0001;
    push_exp(2'd0, 12'hA5C);
    wait_frames(1);
    @(posedge CLK);
    #1 req = 4'b0000;
    repeat (2) @(negedge CLK);
    check_eq("busy_idle", 32'({busy, ser_send, ser_load}), 32'd0);

    // all requesters held: 0,1,2,3,0 at a 15-cycle period
    do_reset();
    req_data = {12'h333, 12'h222, 12'h111, 12'h000};
    per_chk  = 1'b1;
    base     = frames_done;
    req      = 4'b1111;
    push_exp(2'd0, 12'h000);
    push_exp(2'd1, 12'h111);
    push_exp(2'd2, 12'h222);
    push_exp(2'd3, 12'h333);
    push_exp(2'd0, 12'h000);
    wait_frames(base + 5);
    @(posedge CLK);
    #1 req = 4'b0000;
    per_chk = 1'b0;
    repeat (3) @(posedge CLK);

    // late arrivals during requester 2's frame: 3 then 1
    do_reset();
    base = frames_done;
    req  = 4'b0100;
    push_exp(2'd2, 12'h222);
    repeat (5) @(posedge CLK);
    #1 req = 4'b1110;
    push_exp(2'd3, 12'h333);
    push_exp(2'd1, 12'h111);
    wait_frames(base + 1);
    @(posedge CLK);
    #1 req = 4'b1010;
    wait_frames(base + 2);
    @(posedge CLK);
    #1 req = 4'b0010;
    wait_frames(base + 3);
    @(posedge CLK);
    #1 req = 4'b0000;
    repeat (3) @(posedge CLK);

    // reset in the middle of a frame (cnt==5)
    do_reset();
    base = frames_done;
    req_data[11:0] = 12'h111;
    @(posedge CLK);
    #1 req = 4'b0001;
    push_exp(2'd0, 12'h111);
    repeat (7) @(posedge CLK);
    #3 rst = 1'b1;
    #1;
    check_eq("async_reset", 32'({ser_load, ser_send, ack, busy, ser_data, grant_id}), 32'd0);
    req_data[11:0] = 12'h2B7;
    push_exp(2'd0, 12'h2B7);
    @(posedge CLK);
    #3 rst = 1'b0;
    wait_frames(base + 1);
    @(posedge CLK);
    #1 req = 4'b0000;
    repeat (3) @(posedge CLK);

    // word changes during SEND are not seen until the next frame
    base = frames_done;
    req_data[11:0] = 12'h123;
    @(posedge CLK);
    #1 req = 4'b0001;
    push_exp(2'd0, 12'h123);
    repeat (4) @(posedge CLK);
    #1 req_data[11:0] = 12'hFFF;
    push_exp(2'd0, 12'hFFF);
    wait_frames(base + 2);
    @(posedge CLK);
    #1 req = 4'b0000;
    repeat (3) @(posedge CLK);
    check_eq("q_drained", 32'(exp_q.size()), 32'd0);

    // GAP=0 build with two requesters held
    @(posedge CLK);
    #1 req_b = 4'b0011;
    n = 0;
    while (acks_b < 4 && n < 200) begin
      @(negedge CLK);
      #1;
      n++;
    end
    if (acks_b < 4) check_eq("b_timeout", 32'(acks_b), 32'd4);
    @(posedge CLK);
    #1 req_b = 4'b0000;
    repeat (20) @(posedge CLK);
    check_eq("b_idle", 32'({busy_b, ser_send_b, ser_load_b}), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
